if_prefetch_unit: RTL and testbench
===================================

IF_PREFETCH_UNIT -- requirements
Module: if_prefetch_unit

Interface
REQ-001 Parameter RESET_ADDR, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 4: prefetch buffer entries; power of two, 2..16.
REQ-003 Parameter NOP_INST, default 32'h0000_0013: instruction word carried by exception entries.
REQ-004 clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 redirect_i  in  1  branch/jump taken; flush and refetch from redirect_addr_i.
REQ-007 redirect_addr_i  in  32  new fetch address.
REQ-008 id_stall_i  in  1  decode stage cannot accept the head entry this cycle.
REQ-009 id_valid_o  out  1  head entry valid.
REQ-010 id_inst_o / id_pc_o / id_pc_add4_o  out  32 each  head instruction, its PC, PC+4.
REQ-011 id_exc_addr_o  out  1  head entry is an instruction-address-misaligned exception.
REQ-012 id_exc_bus_o  out  1  head entry is an instruction bus-error exception.
REQ-013 wbm_addr_o  out  32  Wishbone classic fetch address.
REQ-014 wbm_cyc_o / wbm_stb_o  out  1 each  Wishbone cycle / strobe.
REQ-015 wbm_dat_i  in  32  fetched word; wbm_ack_i / wbm_err_i  in  1 each  terminate cycle.
REQ-016 fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current number of buffered entries.

Function
REQ-017 FSM states SHALL be IDLE, BUSY, DROP, HALT.
REQ-018 IDLE: if level + 0 < FIFO_DEPTH and no redirect, assert cyc/stb with wbm_addr_o = fetch_pc next cycle and go BUSY.
REQ-019 BUSY/DROP: wbm_cyc_o = wbm_stb_o = 1, wbm_addr_o stable until wbm_ack_i or wbm_err_i sampled high.
REQ-020 BUSY + ack: push {wbm_dat_i, fetch_pc, fetch_pc+4, exc=0}; fetch_pc += 4 (mod 2^32 wrap); go IDLE.
REQ-021 BUSY + err: push {NOP_INST, fetch_pc, fetch_pc+4, exc_bus=1}; go HALT.
REQ-022 ack and err both high: treat as err.
REQ-023 DROP + ack/err: discard response, no push; go IDLE.
REQ-024 HALT: no bus activity; leave only on redirect_i.
REQ-025 Only one outstanding bus cycle; a new cycle is never issued while a slot is not reserved, so FIFO cannot overflow.
REQ-026 redirect_i (any state): FIFO emptied same edge (level 0 next cycle), fetch_pc <= redirect_addr_i; BUSY -> DROP, DROP stays DROP, IDLE/HALT -> IDLE.
REQ-027 Redirect with redirect_addr_i[1:0] != 0: push single entry {NOP_INST, redirect_addr_i, +4, exc_addr=1} after flush, no bus cycle, go HALT (DROP first if a cycle is outstanding, then HALT).
REQ-028 id_valid_o = (level != 0); head outputs driven from FIFO storage, zero when empty.
REQ-029 Pop when id_valid_o && !id_stall_i && !redirect_i; redirect wins over pop and push.
REQ-030 Simultaneous push and pop: level unchanged, both take effect.
REQ-031 Pointers wrap modulo FIFO_DEPTH; full = level == FIFO_DEPTH.
REQ-032 Latency: ack sampled at edge N -> id_valid_o high after edge N when FIFO was empty.
REQ-033 Sustained throughput with zero-wait slave: one word per two cycles (IDLE/BUSY alternation).

Reset
REQ-034 rst_i high at an edge: state IDLE, fetch_pc = RESET_ADDR, level 0, pointers 0.
REQ-035 During and after reset until next issue: wbm_cyc_o = wbm_stb_o = 0, wbm_addr_o = 0, id_valid_o = 0, all id_* = 0.
REQ-036 Reset mid bus cycle: cycle abandoned immediately (cyc low next cycle), late ack after reset ignored.
REQ-037 First cycle issued the cycle after rst_i deasserts, wbm_addr_o = RESET_ADDR.

Verification
REQ-038 Reset, slave acks 1 cycle after stb with 0xAAAA0000+addr -> entries PC 0,4,8,12 in order, inst 0xAAAA0000..0xAAAA000C, level saturates at 4 with id_stall_i=1, no 5th request.
REQ-039 Redirect to 0x100 while BUSY at 0x8 -> cyc held until ack, that word dropped, level 0, next request at 0x100, first entry PC 0x100.
REQ-040 Redirect to 0x102 -> no bus cycle, one entry PC 0x102, exc_addr=1, inst 0x00000013, then HALT until redirect to 0x200 resumes at 0x200.
REQ-041 wbm_err_i on fetch at 0x10 -> entry PC 0x10, exc_bus=1, inst 0x00000013, no further cycles.
REQ-042 FIFO full, id_stall_i=0 with push and pop same cycle -> level stays constant, order preserved; fetch_pc 0xFFFFFFFC wraps to 0x00000000.
REQ-043 rst_i asserted while BUSY, ack arrives next cycle -> no push, level 0, restart at RESET_ADDR.

Source files
------------

// File: rtl/if_prefetch_unit_if.sv
// Bundle of the prefetch unit's decode-side and Wishbone-side signals.
//
// Handshake semantics (both sides):
//   Decode side: an entry transfers on a rising edge where id_valid_o = 1,
//   id_stall_i = 0 and redirect_i = 0. The head entry (id_inst_o, id_pc_o,
//   id_pc_add4_o, id_exc_*) is held stable while id_valid_o = 1 and it
//   has not transferred. redirect_i flushes everything buffered.
//   Bus side: Wishbone classic. A cycle is open while wbm_cyc_o = wbm_stb_o = 1,
//   with wbm_addr_o held stable; it ends on the first edge where wbm_ack_i or
//   wbm_err_i is sampled high. Only one cycle is ever outstanding.
//
// Modports:
//   master - the prefetch unit
//   slave  - the environment (decode stage + Wishbone slave)
interface if_prefetch_unit_if;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        id_stall_i;
  logic        id_valid_o;
  logic [31:0] id_inst_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_pc_add4_o;
  logic        id_exc_addr_o;
  logic        id_exc_bus_o;
  logic [31:0] wbm_addr_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;

  modport master (
    input  redirect_i, redirect_addr_i, id_stall_i,
    output id_valid_o, id_inst_o, id_pc_o, id_pc_add4_o, id_exc_addr_o, id_exc_bus_o,
    output wbm_addr_o, wbm_cyc_o, wbm_stb_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i
  );

  modport slave (
    output redirect_i, redirect_addr_i, id_stall_i,
    input  id_valid_o, id_inst_o, id_pc_o, id_pc_add4_o, id_exc_addr_o, id_exc_bus_o,
    input  wbm_addr_o, wbm_cyc_o, wbm_stb_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i
  );
endinterface

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch prefetch unit: fetches sequential words over a Wishbone
// classic bus into a small FIFO that feeds the decode stage. Handles
// redirects (flush + refetch), bus errors and misaligned redirect targets by
// queueing exception entries and halting until the next redirect.
//
// Ports:
//   clk_i, rst_i   - clock, synchronous active-high reset
//   bus            - if_prefetch_unit_if.master (decode + Wishbone signals)
//   fifo_level_o   - number of buffered entries
//   state_o        - fetch FSM state (0 IDLE, 1 BUSY, 2 DROP, 3 HALT)
module if_prefetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  if_prefetch_unit_if.master          bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
  output logic [1:0]                  state_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] addr_q;
  logic        halt_after_drop_q, halt_after_drop_d;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [LW-1:0] level_q;

  logic [31:0] inst_mem [FIFO_DEPTH];
  logic [31:0] pc_mem   [FIFO_DEPTH];
  logic        exc_addr_mem [FIFO_DEPTH];
  logic        exc_bus_mem  [FIFO_DEPTH];

  logic        in_cycle, bus_done, redir_mis, issue, pop, id_valid;
  logic        push, push_exc_addr, push_exc_bus;
  logic [31:0] push_inst, push_pc;
  logic [PW-1:0] rd_base, wr_base;
  logic [LW-1:0] level_base;

  assign in_cycle  = (state_q == BUSY) || (state_q == DROP);
  assign bus_done  = in_cycle && (bus.wbm_ack_i || bus.wbm_err_i);
  assign redir_mis = bus.redirect_i && (bus.redirect_addr_i[1:0] != 2'b00);
  // A cycle is only started when a FIFO slot is free; since nothing else
  // pushes while it is outstanding, that slot stays reserved for its response.
  assign issue     = (state_q == IDLE) && !bus.redirect_i && (level_q < LW'(FIFO_DEPTH));
  assign id_valid  = (level_q != '0);
  assign pop       = id_valid && !bus.id_stall_i && !bus.redirect_i;

  // Next-state, push and fetch-PC logic.
  always_comb begin
    state_d           = state_q;
    fetch_pc_d        = fetch_pc_q;
    halt_after_drop_d = halt_after_drop_q;
    push              = 1'b0;
    push_inst         = bus.wbm_dat_i;
    push_pc           = fetch_pc_q;
    push_exc_addr     = 1'b0;
    push_exc_bus      = 1'b0;
    if (bus.redirect_i) begin
      fetch_pc_d = bus.redirect_addr_i;
      // A cycle terminating on this same edge is already over, so there is
      // nothing left to drop; otherwise wait for its late response.
      if (in_cycle && !bus_done) begin
        state_d           = DROP;
        halt_after_drop_d = redir_mis;
      end else begin
        state_d           = redir_mis ? HALT : IDLE;
        halt_after_drop_d = 1'b0;
      end
      if (redir_mis) begin
        push          = 1'b1;
        push_inst     = NOP_INST;
        push_pc       = bus.redirect_addr_i;
        push_exc_addr = 1'b1;
      end
    end else begin
      unique case (state_q)
        IDLE: if (issue) state_d = BUSY;
        BUSY: begin
          if (bus.wbm_err_i) begin
            push         = 1'b1;
            push_inst    = NOP_INST;
            push_exc_bus = 1'b1;
            state_d      = HALT;
          end else if (bus.wbm_ack_i) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = IDLE;
          end
        end
        DROP: begin
          if (bus.wbm_ack_i || bus.wbm_err_i) begin
            state_d           = halt_after_drop_q ? HALT : IDLE;
            halt_after_drop_d = 1'b0;
          end
        end
        HALT: state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  // A redirect restarts the FIFO from slot 0; the optional exception entry
  // is then written into slot 0 on the same edge.
  always_comb begin
    rd_base    = bus.redirect_i ? '0 : rd_ptr_q;
    wr_base    = bus.redirect_i ? '0 : wr_ptr_q;
    level_base = bus.redirect_i ? '0 : level_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q           <= IDLE;
      fetch_pc_q        <= RESET_ADDR;
      addr_q            <= '0;
      halt_after_drop_q <= 1'b0;
      rd_ptr_q          <= '0;
      wr_ptr_q          <= '0;
      level_q           <= '0;
    end else begin
      state_q           <= state_d;
      fetch_pc_q        <= fetch_pc_d;
      halt_after_drop_q <= halt_after_drop_d;
      if (issue) addr_q <= fetch_pc_q;
      rd_ptr_q          <= rd_base + PW'(pop);
      wr_ptr_q          <= wr_base + PW'(push);
      level_q           <= level_base + LW'(push) - LW'(pop);
    end
  end

  // Storage needs no reset: entries are only visible while the level covers them.
  always_ff @(posedge clk_i) begin
    if (push) begin
      inst_mem[wr_base]     <= push_inst;
      pc_mem[wr_base]       <= push_pc;
      exc_addr_mem[wr_base] <= push_exc_addr;
      exc_bus_mem[wr_base]  <= push_exc_bus;
    end
  end

  assign bus.wbm_cyc_o     = in_cycle;
  assign bus.wbm_stb_o     = in_cycle;
  assign bus.wbm_addr_o    = addr_q;

  assign bus.id_valid_o    = id_valid;
  assign bus.id_inst_o     = id_valid ? inst_mem[rd_ptr_q] : 32'd0;
  assign bus.id_pc_o       = id_valid ? pc_mem[rd_ptr_q] : 32'd0;
  assign bus.id_pc_add4_o  = id_valid ? (pc_mem[rd_ptr_q] + 32'd4) : 32'd0;
  assign bus.id_exc_addr_o = id_valid && exc_addr_mem[rd_ptr_q];
  assign bus.id_exc_bus_o  = id_valid && exc_bus_mem[rd_ptr_q];

  assign fifo_level_o = level_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Bench for if_prefetch_unit: directed scenarios followed by a randomized run,
// checked against a transaction-level model of the fetch stream.
module tb_if_prefetch_unit;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RST_A = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          W     = 98;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] level;
  logic [1:0] state;

  always #5 clk = ~clk;

  if_prefetch_unit_if bus();

  if_prefetch_unit #(.RESET_ADDR(RST_A), .FIFO_DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus),
    .fifo_level_o(level),
    .state_o(state)
  );

  // ---------------- scoreboard / model state ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic        m_out = 1'b0;        // a bus request is expected to be open
  logic        m_drop = 1'b0;       // its response must be thrown away
  logic        m_halt = 1'b0;       // fetching stopped until a redirect
  logic        m_halt_after = 1'b0; // halt once the dropped response arrives
  logic [31:0] m_pc = RST_A;        // next address the stream should fetch
  logic [31:0] m_req = 32'd0;       // address of the open request

  int wait_cnt = 0, cur_wait = 0, min_wait = 0, max_wait = 0, err_pct = 0;
  bit rnd_data = 1'b0;

  function automatic logic [W-1:0] mk(input logic [31:0] inst, input logic [31:0] pc,
                                      input logic ea, input logic eb);
    return {inst, pc, pc + 32'd4, ea, eb};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver: one clock cycle of stimulus + model update ----------------
  task automatic step(input logic r, input logic rd, input logic [31:0] ra,
                      input logic st, input logic fack);
    logic ack, err, mis;
    logic [31:0] dat;
    int lvl_now;
    @(negedge clk);
    if (rst) begin
      check("reset_outputs",
            {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_addr_o, bus.id_valid_o, bus.id_inst_o,
             bus.id_pc_o, bus.id_pc_add4_o, bus.id_exc_addr_o, bus.id_exc_bus_o, level}, 128'd0);
    end else begin
      check("wbm_cyc_stb", {bus.wbm_cyc_o, bus.wbm_stb_o}, {m_out, m_out});
      if (m_out) check("wbm_addr", bus.wbm_addr_o, m_req);
    end
    // Wishbone slave with a per-request wait count
    ack = 1'b0;
    err = 1'b0;
    dat = rnd_data ? $urandom : (32'hAAAA_0000 + bus.wbm_addr_o);
    if (fack) ack = 1'b1;
    else if (!bus.wbm_cyc_o) wait_cnt = 0;
    else if (!r) begin
      if (wait_cnt >= cur_wait) begin
        if (int'($urandom_range(99)) < err_pct) begin
          err = 1'b1;
          ack = 1'($urandom_range(1));
        end else ack = 1'b1;
        wait_cnt = 0;
        cur_wait = int'($urandom_range(max_wait, min_wait));
      end else wait_cnt++;
    end
    rst                 = r;
    bus.redirect_i      = rd;
    bus.redirect_addr_i = ra;
    bus.id_stall_i      = st;
    bus.wbm_ack_i       = ack;
    bus.wbm_err_i       = err;
    bus.wbm_dat_i       = dat;
    lvl_now = exp_q.size();
    #2;
    // model of the fetch stream for the coming edge
    if (r) begin
      exp_q.delete();
      m_out = 0; m_drop = 0; m_halt = 0; m_halt_after = 0; m_pc = RST_A;
    end else if (rd) begin
      exp_q.delete();
      mis  = (ra[1:0] != 2'b00);
      m_pc = ra;
      if (m_out && !(ack || err)) begin
        m_drop = 1; m_halt_after = mis;
      end else begin
        m_out = 0; m_drop = 0; m_halt_after = 0; m_halt = mis;
      end
      if (mis) exp_q.push_back(mk(NOP, ra, 1'b1, 1'b0));
    end else if (m_out) begin
      if (ack || err) begin
        m_out = 0;
        if (m_drop) begin
          m_drop = 0; m_halt = m_halt_after; m_halt_after = 0;
        end else if (err) begin
          exp_q.push_back(mk(NOP, m_req, 1'b0, 1'b1));
          m_halt = 1;
        end else begin
          exp_q.push_back(mk(dat, m_req, 1'b0, 1'b0));
          m_pc = m_pc + 32'd4;
        end
      end
    end else if (!m_halt && lvl_now < DEPTH) begin
      m_out = 1;
      m_req = m_pc;
    end
  endtask

  task automatic reset_dut();
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic run(input int n, input int stall_pct);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 32'd0, int'($urandom_range(99)) < stall_pct, 1'b0);
  endtask

  // ---------------- monitor: compares whatever the decode side accepts ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      check("fifo_level", level, exp_q.size());
      check("id_valid", bus.id_valid_o, exp_q.size() != 0);
      if (exp_q.size() == 0)
        check("empty_head_zero", {bus.id_inst_o, bus.id_pc_o, bus.id_pc_add4_o,
                                  bus.id_exc_addr_o, bus.id_exc_bus_o}, 128'd0);
      if (bus.id_valid_o === 1'b1 && !bus.id_stall_i && !bus.redirect_i && !rst) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_entry: got pc %h expected no entry", bus.id_pc_o);
        end else begin
          e = exp_q.pop_front();
          check("id_entry", {bus.id_inst_o, bus.id_pc_o, bus.id_pc_add4_o,
                             bus.id_exc_addr_o, bus.id_exc_bus_o}, e);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    bit hit;
    logic r, rd;
    logic [31:0] ra;
    bus.redirect_i = 0; bus.redirect_addr_i = 0; bus.id_stall_i = 0;
    bus.wbm_dat_i = 0; bus.wbm_ack_i = 0; bus.wbm_err_i = 0;

    // reset, zero-wait slave, decode stalled: fill to DEPTH, no 5th request
    reset_dut();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    check("level_saturated", level, 3'd4);
    run(16, 0);

    // redirect to 0x100 while the fetch at 0x8 is still open
    min_wait = 2; max_wait = 2;
    reset_dut();
    hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(posedge clk);
      #1;
      if (bus.wbm_cyc_o === 1'b1 && bus.wbm_addr_o === 32'h8) hit = 1;
      else step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    end
    check("busy_at_8_seen", hit, 1);
    step(1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
    run(20, 0);

    // misaligned redirect, halt, resume
    min_wait = 0; max_wait = 1;
    step(1'b0, 1'b1, 32'h102, 1'b0, 1'b0);
    run(8, 0);
    step(1'b0, 1'b1, 32'h200, 1'b0, 1'b0);
    run(12, 20);

    // bus error on the fetch at 0x10
    err_pct = 100; min_wait = 0; max_wait = 0;
    step(1'b0, 1'b1, 32'h10, 1'b0, 1'b0);
    run(10, 0);
    err_pct = 0;

    // address wrap, full FIFO with simultaneous push/pop
    step(1'b0, 1'b1, 32'hFFFF_FFF0, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    run(20, 0);
    run(20, 40);

    // reset while a cycle is open, late ack afterwards
    min_wait = 2; max_wait = 2;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge clk);
      #1;
      if (bus.wbm_cyc_o === 1'b1) hit = 1;
      else step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    end
    check("busy_before_reset_seen", hit, 1);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    run(12, 0);

    // randomized run
    rnd_data = 1; min_wait = 0; max_wait = 2; err_pct = 3;
    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(199) == 0);
      rd = ($urandom_range(99) < 4);
      ra = 32'($urandom_range(63)) << 2;
      if ($urandom_range(9) == 0) ra = 32'hFFFF_FFF8;
      if ($urandom_range(3) == 0) ra[1:0] = 2'($urandom_range(3, 1));
      step(r, rd, ra, $urandom_range(99) < 30, 1'b0);
    end
    run(10, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
